// File: rtl/msk_modulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | msk_modulator : serial bits -> continuous-phase MSK baseband I/Q samples    |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module msk_modulator #(
   parameter int OSF          = 20,
   parameter int WO           = 16,
   parameter int CLK_PER_SAMP = 4,
   parameter int AMP          = 2**(WO-1)-1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 en_i,
   input  logic                 bit_i,
   input  logic                 bit_valid_i,
   output logic                 bit_ready_o,
   output logic signed [WO-1:0] i_o,
   output logic signed [WO-1:0] q_o,
   output logic                 iq_val_o,
   output logic                 sym_valid_o,
   output logic                 underrun_o
);

   localparam int  NPH = 4*OSF;
   localparam int  PW  = $clog2(NPH);
   localparam int  SW  = $clog2(OSF);
   localparam int  CW  = (CLK_PER_SAMP > 1) ? $clog2(CLK_PER_SAMP) : 1;
   localparam real PI  = 3.14159265358979323846;

   function automatic logic signed [WO-1:0] lut_val(input int p, input bit want_sin);
      real a;
      real v;
      a = 2.0 * PI * real'(p) / real'(NPH);
      v = (want_sin ? $sin(a) : $cos(a)) * real'(AMP);
      if (v >= 0.0) return WO'($rtoi(v + 0.5));
      else          return WO'(-$rtoi(-v + 0.5));
   endfunction

   logic signed [WO-1:0] cos_tab [NPH];
   logic signed [WO-1:0] sin_tab [NPH];

   for (genvar g = 0; g < NPH; g++) begin : g_lut
      localparam logic signed [WO-1:0] C_COS = lut_val(g, 1'b0);
      localparam logic signed [WO-1:0] C_SIN = lut_val(g, 1'b1);
      assign cos_tab[g] = C_COS;
      assign sin_tab[g] = C_SIN;
   end

   logic [CW-1:0]        samp_cnt_q, samp_cnt_d;
   logic [SW-1:0]        sym_idx_q, sym_idx_d;
   logic [PW-1:0]        phase_q, phase_d;
   logic                 idle_bit_q, idle_bit_d;
   logic                 cur_bit_q, cur_bit_d;
   logic                 underrun_q, underrun_d;
   logic signed [WO-1:0] i_q, i_d;
   logic signed [WO-1:0] q_q, q_d;
   logic                 iq_val_q, iq_val_d;
   logic                 sym_valid_q, sym_valid_d;

   logic tick;
   logic bit_ready;
   logic sym_bit;

   always_comb begin
      tick        = en_i && (samp_cnt_q == CW'(CLK_PER_SAMP-1));
      bit_ready   = tick && (sym_idx_q == '0);
      // The sample-0 tick steers the phase with the bit being taken right now.
      sym_bit     = bit_ready ? (bit_valid_i ? bit_i : idle_bit_q) : cur_bit_q;

      samp_cnt_d  = samp_cnt_q;
      sym_idx_d   = sym_idx_q;
      phase_d     = phase_q;
      idle_bit_d  = idle_bit_q;
      cur_bit_d   = cur_bit_q;
      underrun_d  = underrun_q;
      i_d         = i_q;
      q_d         = q_q;
      iq_val_d    = 1'b0;
      sym_valid_d = 1'b0;

      if (!en_i) begin
         samp_cnt_d = '0;
         sym_idx_d  = '0;
         phase_d    = '0;
         idle_bit_d = 1'b0;
         cur_bit_d  = 1'b0;
         i_d        = '0;
         q_d        = '0;
      end else begin
         samp_cnt_d = tick ? '0 : samp_cnt_q + CW'(1);
         if (bit_ready) begin
            cur_bit_d = sym_bit;
            if (!bit_valid_i) begin
               idle_bit_d = ~idle_bit_q;
               underrun_d = 1'b1;
            end
         end
         if (tick) begin
            i_d         = cos_tab[phase_q];
            q_d         = sin_tab[phase_q];
            iq_val_d    = 1'b1;
            sym_valid_d = (sym_idx_q == '0);
            if (sym_bit) phase_d = (phase_q == PW'(NPH-1)) ? '0 : phase_q + PW'(1);
            else         phase_d = (phase_q == '0) ? PW'(NPH-1) : phase_q - PW'(1);
            sym_idx_d   = (sym_idx_q == SW'(OSF-1)) ? '0 : sym_idx_q + SW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         samp_cnt_q  <= '0;
         sym_idx_q   <= '0;
         phase_q     <= '0;
         idle_bit_q  <= 1'b0;
         cur_bit_q   <= 1'b0;
         underrun_q  <= 1'b0;
         i_q         <= '0;
         q_q         <= '0;
         iq_val_q    <= 1'b0;
         sym_valid_q <= 1'b0;
      end else begin
         samp_cnt_q  <= samp_cnt_d;
         sym_idx_q   <= sym_idx_d;
         phase_q     <= phase_d;
         idle_bit_q  <= idle_bit_d;
         cur_bit_q   <= cur_bit_d;
         underrun_q  <= underrun_d;
         i_q         <= i_d;
         q_q         <= q_d;
         iq_val_q    <= iq_val_d;
         sym_valid_q <= sym_valid_d;
      end
   end

   assign bit_ready_o = bit_ready;
   assign i_o         = i_q;
   assign q_o         = q_q;
   assign iq_val_o    = iq_val_q;
   assign sym_valid_o = sym_valid_q;
   assign underrun_o  = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_msk_modulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_msk_modulator : self-checking bench for the MSK modulator               |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module tb_msk_modulator;

   localparam int  OSF = 20;
   localparam int  WO  = 16;
   localparam int  CPS = 4;
   localparam int  AMP = 32767;
   localparam int  NPH = 4*OSF;
   localparam real PI  = 3.14159265358979323846;

   typedef struct { int i; int q; int sv; } samp_t;
   typedef struct { int tst; int idx; int ei; int eq; int es; } vec_t;

   logic clk = 1'b0, reset_n = 1'b0, en = 1'b0, bit_d = 1'b0, bit_v = 1'b0;
   logic bit_ready, iq_val, sym_valid, underrun;
   logic signed [WO-1:0] i_s, q_s;
   logic en1 = 1'b0, bit1_d = 1'b0, bit1_v = 1'b1;
   logic bit_ready1, iq_val1, sym_valid1, underrun1;
   logic signed [WO-1:0] i1, q1;

   int    n_cmp = 0, n_bad = 0, cyc = 0, en_cyc = 0;
   int    cap_n = 0, acc_cnt = 0, m_phase = 0, strobes_since = 0;
   bit    tb_idle = 1'b0, seen_ready = 1'b0;
   samp_t sbq[$];
   vec_t  vt[$];
   int    cap_i [8192];
   int    cap_q [8192];
   int    cap_s [8192];
   int    cap_c [8192];

   msk_modulator #(.OSF(OSF), .WO(WO), .CLK_PER_SAMP(CPS), .AMP(AMP)) dut (
      .clk(clk), .reset_n(reset_n), .en_i(en), .bit_i(bit_d), .bit_valid_i(bit_v),
      .bit_ready_o(bit_ready), .i_o(i_s), .q_o(q_s), .iq_val_o(iq_val),
      .sym_valid_o(sym_valid), .underrun_o(underrun));

   msk_modulator #(.OSF(OSF), .WO(WO), .CLK_PER_SAMP(1), .AMP(AMP)) dut1 (
      .clk(clk), .reset_n(reset_n), .en_i(en1), .bit_i(bit1_d), .bit_valid_i(bit1_v),
      .bit_ready_o(bit_ready1), .i_o(i1), .q_o(q1), .iq_val_o(iq_val1),
      .sym_valid_o(sym_valid1), .underrun_o(underrun1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic int rnd(input real x);
      if (x >= 0.0) return $rtoi($floor(x + 0.5));
      else          return -$rtoi($floor(-x + 0.5));
   endfunction
   function automatic int ecos(input int p);
      return rnd(real'(AMP) * $cos(2.0 * PI * real'(p) / real'(NPH)));
   endfunction
   function automatic int esin(input int p);
      return rnd(real'(AMP) * $sin(2.0 * PI * real'(p) / real'(NPH)));
   endfunction
   function automatic int wrap(input int x);
      return ((x % NPH) + NPH) % NPH;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_iq(input string nm, input int ai, input int aq, input int as_,
                         input int ei, input int eq, input int es);
      n_cmp++;
      if (ai != ei || aq != eq || as_ != es) begin
         n_bad++;
         $display("FAIL %s: got (%0d,%0d,sv=%0d), required (%0d,%0d,sv=%0d) (t=%0t)",
                  nm, ai, aq, as_, ei, eq, es, $time);
      end
   endtask

   // Reference: each symbol decision queues the OSF samples it must produce.
   always @(negedge clk) begin : monitor
      samp_t e;
      int    b;
      if (iq_val) begin
         strobes_since++;
         if (cap_n < 8192) begin
            cap_i[cap_n] = int'(i_s);
            cap_q[cap_n] = int'(q_s);
            cap_s[cap_n] = int'(sym_valid);
            cap_c[cap_n] = cyc;
            cap_n++;
         end
         if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_strobe: got strobe (%0d,%0d), required no strobe (t=%0t)",
                     i_s, q_s, $time);
         end else begin
            e = sbq.pop_front();
            chk_iq("sb_sample", int'(i_s), int'(q_s), int'(sym_valid), e.i, e.q, e.sv);
         end
      end
      if (bit_ready) begin
         if (seen_ready) chk("ticks_per_symbol", strobes_since, OSF);
         seen_ready    = 1'b1;
         strobes_since = 0;
         if (bit_v) begin
            b = int'(bit_d);
            acc_cnt++;
         end else begin
            b = int'(tb_idle);
            tb_idle = ~tb_idle;
         end
         for (int k = 0; k < OSF; k++) begin
            e.i  = ecos(wrap(m_phase + (b != 0 ? k : -k)));
            e.q  = esin(wrap(m_phase + (b != 0 ? k : -k)));
            e.sv = (k == 0) ? 1 : 0;
            sbq.push_back(e);
         end
         m_phase = wrap(m_phase + (b != 0 ? OSF : -OSF));
      end
   end

   task automatic sb_clear();
      sbq.delete();
      m_phase       = 0;
      tb_idle       = 1'b0;
      seen_ready    = 1'b0;
      strobes_since = 0;
   endtask

   task automatic tick_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      en      = 1'b0;
      en1     = 1'b0;
      bit_v   = 1'b0;
      reset_n = 1'b0;
      sb_clear();
      tick_clk(2);
      reset_n = 1'b1;
      tick_clk(1);
   endtask

   task automatic wait_caps(input int n, input int budget, input string nm);
      int t;
      t = 0;
      while (cap_n < n && t < budget) begin
         @(negedge clk);
         t++;
      end
      chk(nm, int'(cap_n >= n), 1);
   endtask

   task automatic send_bit(input logic b, input int budget, input string nm);
      int t;
      t     = 0;
      bit_d = b;
      bit_v = 1'b1;
      do begin
         @(negedge clk);
         t++;
      end while (!bit_ready && t < budget);
      chk(nm, int'(bit_ready), 1);
      @(posedge clk);
      #1;
   endtask

   task automatic run_tab(input int tst, input string nm);
      foreach (vt[n]) begin
         if (vt[n].tst == tst)
            chk_iq($sformatf("%s[%0d]", nm, vt[n].idx), cap_i[vt[n].idx], cap_q[vt[n].idx],
                   cap_s[vt[n].idx], vt[n].ei, vt[n].eq, vt[n].es);
      end
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, %0d compared / %0d bad", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic abits [4];
      abits = '{1'b1, 1'b0, 1'b1, 1'b0};

      // rotation, all ones
      vt.push_back('{0,  0, 32767,      0, 1});
      vt.push_back('{0, 10, 23170,  23170, 0});
      vt.push_back('{0, 20,     0,  32767, 1});
      vt.push_back('{0, 40, -32767,     0, 1});
      vt.push_back('{0, 60,     0, -32767, 1});
      vt.push_back('{0, 80, 32767,      0, 1});
      // alternating 1,0,1,0: phase swings 0 -> 20 -> 0
      vt.push_back('{1,  0, 32767,      0, 1});
      vt.push_back('{1, 10, 23170,  23170, 0});
      vt.push_back('{1, 20,     0,  32767, 1});
      vt.push_back('{1, 30, 23170,  23170, 0});
      vt.push_back('{1, 40, 32767,      0, 1});
      vt.push_back('{1, 60,     0,  32767, 1});
      // underrun: idle bits 0,1,0,1
      vt.push_back('{2,  0, 32767,      0, 1});
      vt.push_back('{2, 10, 23170, -23170, 0});
      vt.push_back('{2, 20,     0, -32767, 1});
      vt.push_back('{2, 40, 32767,      0, 1});
      vt.push_back('{2, 60,     0, -32767, 1});

      tick_clk(3);
      chk("rst_i", int'(i_s), 0);
      chk("rst_q", int'(q_s), 0);
      chk("rst_iq_val", int'(iq_val), 0);
      chk("rst_sym_valid", int'(sym_valid), 0);
      chk("rst_ready", int'(bit_ready), 0);
      chk("rst_underrun", int'(underrun), 0);
      reset_n = 1'b1;
      tick_clk(2);

      // basic rotation
      cap_n = 0;
      bit_d = 1'b1;
      bit_v = 1'b1;
      en    = 1'b1;
      en_cyc = cyc;
      wait_caps(81, 1000, "rot_wait");
      chk("rot_latency", cap_c[0] - en_cyc + 1, CPS + 1);
      run_tab(0, "rot");
      for (int k = 1; k <= 80; k++) begin
         chk("rot_period", cap_c[k] - cap_c[k-1], CPS);
         chk("rot_symstrobe", cap_s[k], (k % OSF == 0) ? 1 : 0);
      end

      // alternating bits
      do_reset();
      cap_n = 0;
      bit_d = 1'b1;
      bit_v = 1'b1;
      en    = 1'b1;
      for (int k = 0; k < 4; k++) send_bit(abits[k], 200, "alt_handshake");
      bit_v = 1'b0;
      wait_caps(61, 200, "alt_wait");
      run_tab(1, "alt");

      // underrun with valid low from reset
      do_reset();
      cap_n = 0;
      chk("und_before", int'(underrun), 0);
      en = 1'b1;
      wait_caps(61, 1000, "und_wait");
      run_tab(2, "und");
      chk("und_set", int'(underrun), 1);
      en = 1'b0;
      tick_clk(1);
      sb_clear();
      tick_clk(10);
      chk("und_sticky", int'(underrun), 1);
      chk("und_no_strobe", int'(iq_val), 0);
      do_reset();
      chk("und_cleared", int'(underrun), 0);

      // disable at sym_idx 7, restart, then async reset mid-cycle
      cap_n = 0;
      bit_d = 1'b1;
      bit_v = 1'b1;
      en    = 1'b1;
      wait_caps(7, 200, "dis_wait");
      @(posedge clk);
      #1;
      en = 1'b0;
      sb_clear();
      tick_clk(100);
      chk("dis_no_strobe", cap_n, 7);
      chk("dis_i", int'(i_s), 0);
      chk("dis_q", int'(q_s), 0);
      chk("dis_ready", int'(bit_ready), 0);
      cap_n  = 0;
      en     = 1'b1;
      en_cyc = cyc;
      wait_caps(1, 50, "restart_wait");
      chk("restart_latency", cap_c[0] - en_cyc + 1, CPS + 1);
      chk_iq("restart_first", cap_i[0], cap_q[0], cap_s[0], 32767, 0, 1);
      bit_v = 1'b0;
      wait_caps(26, 500, "arst_wait");
      chk("arst_pre_underrun", int'(underrun), 1);
      chk("arst_pre_i_nonzero", int'(i_s != 0), 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_i", int'(i_s), 0);
      chk("arst_q", int'(q_s), 0);
      chk("arst_underrun", int'(underrun), 0);
      chk("arst_iq_val", int'(iq_val), 0);
      sb_clear();
      @(posedge clk);
      #1;
      en      = 1'b0;
      reset_n = 1'b1;

      // phase wrap with a sample every clock
      do_reset();
      bit1_d = 1'b0;
      bit1_v = 1'b1;
      en1    = 1'b1;
      begin : wrap_seq
         int t;
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (!iq_val1 && t < 10);
         chk("wrap_first_strobe", int'(iq_val1), 1);
         chk_iq("wrap_s0", int'(i1), int'(q1), int'(sym_valid1), 32767, 0, 1);
         for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            chk("wrap_strobe", int'(iq_val1), 1);
            if (k == 1)  chk_iq("wrap_s1", int'(i1), int'(q1), int'(sym_valid1), 32666, -2571, 0);
            if (k == 19) chk("wrap_ready", int'(bit_ready1), 1);
            if (k == 20) chk_iq("wrap_s20", int'(i1), int'(q1), int'(sym_valid1), 0, -32767, 1);
            if (k == 40) chk_iq("wrap_s40", int'(i1), int'(q1), int'(sym_valid1), -32767, 0, 1);
         end
         chk("wrap_underrun", int'(underrun1), 0);
      end
      en1 = 1'b0;

      // backpressure: random bits arriving mid-symbol
      do_reset();
      cap_n   = 0;
      acc_cnt = 0;
      for (int n = 0; n < 200; n++) begin
         bit_d = 1'($urandom_range(1, 0));
         bit_v = 1'b1;
         if (n == 0) en = 1'b1;
         send_bit(bit_d, 400, "bp_handshake");
         bit_v = 1'b0;
         if (n < 199) tick_clk($urandom_range(60, 0));
      end
      tick_clk(78);
      chk("bp_drain", sbq.size(), 0);
      chk("bp_accepted", acc_cnt, 200);
      chk("bp_underrun", int'(underrun), 0);
      en = 1'b0;
      tick_clk(1);
      sb_clear();
      tick_clk(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
